// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - MBIST read-response checker with sticky fail, first fail address and fail count
//
// Purpose: tracks the read requests issued to the memory under test, pairs each one with
// the memory read data RD_LAT cycles later, compares that data with the expected value and
// accumulates the pass/fail result. At the end of a run it gives a one-cycle result pulse.
//
// Ports:
//   clk               clock, all state on posedge
//   rst               asynchronous active-high reset
//   Test              test enable level, high for the whole BIST run
//   re                read request issued to memory this cycle
//   rdaddr            read address, qualified by re
//   exp_data          expected read data, aligned with re/rdaddr
//   test_done         one-cycle pulse: last read request issued
//   rd_data           memory read data, valid RD_LAT cycles after re
//   bist_status       0 = pass, 1 = fail; held until the next run starts
//   bist_check_valid  one-cycle pulse: bist_status is final
//   fail_addr         address of the first mismatch in the current run
//   fail_count        number of mismatching reads, saturating

module bist_response_analyzer #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4,
  parameter int RD_LAT = 1,
  parameter int CWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Test,
  input  logic              re,
  input  logic [AWIDTH-1:0] rdaddr,
  input  logic [DWIDTH-1:0] exp_data,
  input  logic              test_done,
  input  logic [DWIDTH-1:0] rd_data,
  output logic              bist_status,
  output logic              bist_check_valid,
  output logic [AWIDTH-1:0] fail_addr,
  output logic [CWIDTH-1:0] fail_count
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    REPORT,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  // Delay line carrying each request until its read data returns.
  logic [RD_LAT-1:0] v_pipe;
  logic [AWIDTH-1:0] a_pipe [RD_LAT];
  logic [DWIDTH-1:0] e_pipe [RD_LAT];

  logic [CNT_W-1:0]  drain_cnt;
  logic              fail_flag;

  logic              v_d;
  logic [AWIDTH-1:0] a_d;
  logic [DWIDTH-1:0] e_d;
  logic              compare_en;
  logic              mismatch;
  logic              start_run;

  assign v_d = v_pipe[RD_LAT-1];
  assign a_d = a_pipe[RD_LAT-1];
  assign e_d = e_pipe[RD_LAT-1];

  assign compare_en = (state == RUN) || (state == DRAIN);
  // v_d gates the data compare so rd_data is don't-care when no read is returning.
  assign mismatch   = compare_en && v_d && (rd_data != e_d);
  assign start_run  = (state == IDLE) && (next_state == RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; dropping Test aborts a run without reporting.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Test) next_state = RUN;
      end
      RUN: begin
        if (!Test)          next_state = IDLE;
        else if (test_done) next_state = DRAIN;
      end
      DRAIN: begin
        if (!Test)                           next_state = IDLE;
        else if (drain_cnt == CNT_W'(1))     next_state = REPORT;
      end
      REPORT: begin
        next_state = DONE;
      end
      DONE: begin
        if (!Test) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request delay line. Only requests issued while running enter it, and
  // everything in flight is discarded while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        a_pipe[i] <= '0;
        e_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= re && (state == RUN);
      a_pipe[0] <= rdaddr;
      e_pipe[0] <= exp_data;
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end
      if (state == IDLE) begin
        v_pipe <= '0;
      end
    end
  end

  // Drain counter: keeps the FSM in DRAIN for exactly RD_LAT cycles so the
  // last request issued with test_done is compared before reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if ((state == RUN) && (next_state == DRAIN)) begin
      drain_cnt <= CNT_W'(RD_LAT);
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

  // Result accumulation and reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_flag        <= 1'b0;
      fail_addr        <= '0;
      fail_count       <= '0;
      bist_status      <= 1'b0;
      bist_check_valid <= 1'b0;
    end else begin
      if (start_run) begin
        fail_flag   <= 1'b0;
        fail_addr   <= '0;
        fail_count  <= '0;
        bist_status <= 1'b0;
      end else if (mismatch) begin
        fail_flag <= 1'b1;
        if (!fail_flag) begin
          fail_addr <= a_d;
        end
        if (fail_count != {CWIDTH{1'b1}}) begin
          fail_count <= fail_count + CWIDTH'(1);
        end
      end

      // The final compare of a run happens on the same edge that enters
      // REPORT, so the status must fold in the mismatch of that edge.
      bist_check_valid <= (next_state == REPORT);
      if (next_state == REPORT) begin
        bist_status <= fail_flag | mismatch;
      end
    end
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - directed self-checking bench for bist_response_analyzer (RD_LAT 1 and 3)

module tb_bist_response_analyzer;

  logic        clk;
  logic        rst;
  logic        Test;
  logic        re;
  logic [3:0]  rdaddr;
  logic [31:0] exp_data;
  logic        test_done;
  logic        inject;

  logic [31:0] rd_data1;
  logic [31:0] rd_data3;
  logic        status1, valid1, status3, valid3;
  logic [3:0]  addr1, addr3;
  logic [7:0]  count1, count3;

  int compared;
  int mismatched;

  // Memory model: returns expected data, or 0 for an injected fault, with the
  // read latency of each instance; X when no read is returning.
  logic        pv1, pv2, pv3;
  logic [31:0] pd1, pd2, pd3;

  always @(posedge clk) begin
    pv1 <= re;
    pd1 <= inject ? 32'h0 : exp_data;
    pv2 <= pv1;
    pd2 <= pd1;
    pv3 <= pv2;
    pd3 <= pd2;
  end

  assign rd_data1 = pv1 ? pd1 : {32{1'bx}};
  assign rd_data3 = pv3 ? pd3 : {32{1'bx}};

  bist_response_analyzer #(
    .DWIDTH(32), .AWIDTH(4), .RD_LAT(1), .CWIDTH(8)
  ) dut1 (
    .clk(clk), .rst(rst), .Test(Test), .re(re), .rdaddr(rdaddr),
    .exp_data(exp_data), .test_done(test_done), .rd_data(rd_data1),
    .bist_status(status1), .bist_check_valid(valid1),
    .fail_addr(addr1), .fail_count(count1)
  );

  bist_response_analyzer #(
    .DWIDTH(32), .AWIDTH(4), .RD_LAT(3), .CWIDTH(8)
  ) dut3 (
    .clk(clk), .rst(rst), .Test(Test), .re(re), .rdaddr(rdaddr),
    .exp_data(exp_data), .test_done(test_done), .rd_data(rd_data3),
    .bist_status(status3), .bist_check_valid(valid3),
    .fail_addr(addr3), .fail_count(count3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic s1, input logic [3:0] a1, input logic [7:0] c1,
                            input logic s3, input logic [3:0] a3, input logic [7:0] c3);
    check({tag, "_status1"}, 32'(status1), 32'(s1));
    check({tag, "_addr1"},   32'(addr1),   32'(a1));
    check({tag, "_count1"},  32'(count1),  32'(c1));
    check({tag, "_status3"}, 32'(status3), 32'(s3));
    check({tag, "_addr3"},   32'(addr3),   32'(a3));
    check({tag, "_count3"},  32'(count3),  32'(c3));
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] d, input logic inj, input logic done);
    re        = 1'b1;
    rdaddr    = a;
    exp_data  = d;
    inject    = inj;
    test_done = done;
    @(negedge clk);
    re        = 1'b0;
    test_done = 1'b0;
    inject    = 1'b0;
  endtask

  task automatic begin_run();
    Test = 1'b1;
    @(negedge clk);
  endtask

  // Called right after the read carrying test_done; the current negedge is
  // cycle T+1. Expected pulse: RD_LAT=1 at T+2, RD_LAT=3 at T+4.
  task automatic finish_run(input string tag, input logic es, input logic [3:0] ea, input logic [7:0] ec);
    int p1, p3, k1, k3;
    logic s1, s3;
    p1 = 0; p3 = 0; k1 = 0; k3 = 0; s1 = 1'bx; s3 = 1'bx;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      if (valid1) begin p1++; k1 = k; s1 = status1; end
      if (valid3) begin p3++; k3 = k; s3 = status3; end
    end
    check({tag, "_pulses1"}, 32'(p1), 32'd1);
    check({tag, "_cycle1"},  32'(k1), 32'd2);
    check({tag, "_pstat1"},  32'(s1), 32'(es));
    check({tag, "_pulses3"}, 32'(p3), 32'd1);
    check({tag, "_cycle3"},  32'(k3), 32'd4);
    check({tag, "_pstat3"},  32'(s3), 32'(es));
    check_outs(tag, es, ea, ec, es, ea, ec);
    Test = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int p;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; Test = 1'b0; re = 1'b0; rdaddr = '0; exp_data = '0;
    test_done = 1'b0; inject = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_valid1", 32'(valid1), 32'd0);
    check("reset_valid3", 32'(valid3), 32'd0);
    check_outs("reset", 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: fault-free run
    begin_run();
    for (int i = 0; i < 16; i++) rd(4'(i), 32'hA5A5A5A5, 1'b0, i == 15);
    finish_run("t1", 1'b0, 4'd0, 8'd0);

    // 2: stuck-at-0 at address 3 over two march passes
    begin_run();
    for (int i = 0; i < 32; i++) rd(4'(i), 32'hFFFFFFFF, (i % 16) == 3, i == 31);
    finish_run("t2", 1'b1, 4'd3, 8'd2);

    // 3: mismatch only on the last read, issued with test_done
    begin_run();
    for (int i = 0; i < 5; i++) rd(4'(i), 32'h12345678, 1'b0, 1'b0);
    rd(4'd9, 32'h12345678, 1'b1, 1'b1);
    finish_run("t3", 1'b1, 4'd9, 8'd1);

    // 4: 300 mismatches saturate the counter; first address kept
    begin_run();
    for (int i = 0; i < 300; i++) rd(4'((i + 5) % 16), 32'hDEADBEEF, 1'b1, i == 299);
    finish_run("t4", 1'b1, 4'd5, 8'd255);

    // 5: abort mid-RUN, then fault-free rerun
    begin_run();
    check_outs("t5_cleared", 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 4; i++) rd(4'(i + 2), 32'h0F0F0F0F, 1'b1, 1'b0);
    Test = 1'b0;
    p = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid1 || valid3) p++;
    end
    check("t5_abort_pulses", 32'(p), 32'd0);
    check_outs("t5_abort", 1'b0, 4'd2, 8'd4, 1'b0, 4'd2, 8'd2);
    begin_run();
    check_outs("t5_restart", 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h5A5A5A5A, 1'b0, i == 15);
    finish_run("t5_rerun", 1'b0, 4'd0, 8'd0);

    // 6: asynchronous reset during DRAIN
    begin_run();
    for (int i = 0; i < 5; i++) rd(4'(i + 1), 32'hA5A5A5A5, i < 3, i == 4);
    check("t6_pre_count1", 32'(count1), 32'd3);
    check("t6_pre_count3", 32'(count3), 32'd2);
    #1;
    rst  = 1'b1;
    Test = 1'b0;
    #1;
    check("t6_rst_valid1", 32'(valid1), 32'd0);
    check("t6_rst_valid3", 32'(valid3), 32'd0);
    check_outs("t6_rst", 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid1 || valid3) p++;
    end
    check("t6_post_pulses", 32'(p), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
